// File: rtl/div_issue_unit_pkg.sv
// Shared types, constants and helpers for the divider issue front end.
package div_issue_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } div_state_e;

    localparam logic [63:0] ALL_ONES_64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN_INT64   = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN_INT32   = 32'h8000_0000;

    function automatic logic op_is_signed(input logic [1:0] code);
        return (code == OP_DIV) || (code == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] code);
        return (code == OP_REM) || (code == OP_REMU);
    endfunction

    // W-variant results are the low word sign-extended to 64 bits.
    function automatic logic [63:0] word_adjust(input logic [63:0] v, input logic word);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/div_issue_unit_if.sv
// Issue, divider and writeback handshake signals of the divider front end.
interface div_issue_unit_if;
    logic        flush;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic        op_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        div_in_valid;
    logic [63:0] div_in_a;
    logic [63:0] div_in_b;
    logic        div_signed;
    logic        div_flush;
    logic        div_result_valid;
    logic [63:0] div_quotient;
    logic [63:0] div_remainder;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;

    modport slave (
        input  flush, op_valid, op_code, op_word, src1, src2,
               div_result_valid, div_quotient, div_remainder, res_ready,
        output op_ready, div_in_valid, div_in_a, div_in_b, div_signed,
               div_flush, res_valid, res_data
    );

    modport master (
        output flush, op_valid, op_code, op_word, src1, src2,
               div_result_valid, div_quotient, div_remainder, res_ready,
        input  op_ready, div_in_valid, div_in_a, div_in_b, div_signed,
               div_flush, res_valid, res_data
    );
endinterface

// File: rtl/div_operand_prep.sv
// Combinational operand preparation: width extension, signedness and the
// divide-by-zero / signed-overflow cases that never reach the divider.
module div_operand_prep
    import div_issue_unit_pkg::*;
(
    input  logic [1:0]  op_code,
    input  logic        op_word,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic [63:0] opa,
    output logic [63:0] opb,
    output logic        is_signed,
    output logic        fast,
    output logic [63:0] fast_quo,
    output logic [63:0] fast_rem
);
    logic        div_zero;
    logic        overflow;
    logic [63:0] min_neg;

    assign is_signed = op_is_signed(op_code);

    assign opa = !op_word  ? src1 :
                 is_signed ? {{32{src1[31]}}, src1[31:0]} : {32'd0, src1[31:0]};
    assign opb = !op_word  ? src2 :
                 is_signed ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]};

    // Most-negative value of the operating width, as it appears after extension.
    assign min_neg  = op_word ? {32'hFFFF_FFFF, MIN_INT32} : MIN_INT64;
    assign div_zero = (opb == 64'd0);
    assign overflow = is_signed && (opa == min_neg) && (opb == ALL_ONES_64);

    assign fast     = div_zero || overflow;
    assign fast_quo = div_zero ? ALL_ONES_64 : opa;
    assign fast_rem = div_zero ? opa : 64'd0;
endmodule

// File: rtl/div_issue_unit.sv
// Execute-stage front end for the iterative 64-bit divider.
// Optional result cache of the last divider launch: DIV_RESULT_CACHE_EN.
module div_issue_unit
    import div_issue_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    div_issue_unit_if.slave io
);
    div_state_e  state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] res_data_q, res_data_d;
    logic        signed_q, signed_d;
    logic        word_q, word_d;
    logic        rem_q, rem_d;

    logic [63:0] prep_a, prep_b, fast_quo, fast_rem;
    logic        prep_signed, prep_fast;
    logic        op_rem;
    logic        div_done;
    logic        cache_hit;
    logic [63:0] cache_res;

    div_operand_prep u_prep (
        .op_code   (io.op_code),
        .op_word   (io.op_word),
        .src1      (io.src1),
        .src2      (io.src2),
        .opa       (prep_a),
        .opb       (prep_b),
        .is_signed (prep_signed),
        .fast      (prep_fast),
        .fast_quo  (fast_quo),
        .fast_rem  (fast_rem)
    );

    assign op_rem   = op_is_rem(io.op_code);
    // A flush in the completion cycle discards the divider result.
    assign div_done = (state_q == ST_BUSY) && io.div_result_valid && !io.flush;

`ifdef DIV_RESULT_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [63:0] cache_a_q, cache_a_d;
    logic [63:0] cache_b_q, cache_b_d;
    logic [63:0] cache_quo_q, cache_quo_d;
    logic [63:0] cache_rem_q, cache_rem_d;
    logic        cache_signed_q, cache_signed_d;
    logic        cache_word_q, cache_word_d;

    assign cache_hit = cache_valid_q && (cache_a_q == prep_a) && (cache_b_q == prep_b)
                       && (cache_signed_q == prep_signed) && (cache_word_q == io.op_word);
    assign cache_res = word_adjust(op_rem ? cache_rem_q : cache_quo_q, io.op_word);

    always_comb begin
        cache_valid_d  = cache_valid_q;
        cache_a_d      = cache_a_q;
        cache_b_d      = cache_b_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        cache_signed_d = cache_signed_q;
        cache_word_d   = cache_word_q;
        if (div_done) begin
            cache_valid_d  = 1'b1;
            cache_a_d      = a_q;
            cache_b_d      = b_q;
            cache_quo_d    = io.div_quotient;
            cache_rem_d    = io.div_remainder;
            cache_signed_d = signed_q;
            cache_word_d   = word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cache_valid_q <= 1'b0;
        else       cache_valid_q <= cache_valid_d;
    end

    // Cache contents are only meaningful while cache_valid_q is set.
    always_ff @(posedge clk) begin
        cache_a_q      <= cache_a_d;
        cache_b_q      <= cache_b_d;
        cache_quo_q    <= cache_quo_d;
        cache_rem_q    <= cache_rem_d;
        cache_signed_q <= cache_signed_d;
        cache_word_q   <= cache_word_d;
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = 64'd0;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        signed_d   = signed_q;
        word_d     = word_q;
        rem_d      = rem_q;
        res_data_d = res_data_q;
        if (io.flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (io.op_valid) begin
                        a_d      = prep_a;
                        b_d      = prep_b;
                        signed_d = prep_signed;
                        word_d   = io.op_word;
                        rem_d    = op_rem;
                        if (prep_fast) begin
                            res_data_d = word_adjust(op_rem ? fast_rem : fast_quo, io.op_word);
                            state_d    = ST_DONE;
                        end else if (cache_hit) begin
                            res_data_d = cache_res;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: state_d = ST_BUSY;
                ST_BUSY: begin
                    if (div_done) begin
                        res_data_d = word_adjust(rem_q ? io.div_remainder : io.div_quotient, word_q);
                        state_d    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (io.res_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= 64'd0;
            b_q        <= 64'd0;
            signed_q   <= 1'b0;
            word_q     <= 1'b0;
            rem_q      <= 1'b0;
            res_data_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            signed_q   <= signed_d;
            word_q     <= word_d;
            rem_q      <= rem_d;
            res_data_q <= res_data_d;
        end
    end

    assign io.op_ready     = (state_q == ST_IDLE);
    assign io.div_in_valid = (state_q == ST_LAUNCH);
    assign io.div_in_a     = a_q;
    assign io.div_in_b     = b_q;
    assign io.div_signed   = signed_q;
    assign io.div_flush    = io.flush && ((state_q == ST_LAUNCH) || (state_q == ST_BUSY));
    assign io.res_valid    = (state_q == ST_DONE);
    assign io.res_data     = res_data_q;
endmodule

// File: tb/tb_div_issue_unit.sv
// Randomized self-checking bench for div_issue_unit with a behavioural
// RV64M divide model and a bench-side iterative divider stand-in.
module tb_div_issue_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_issue_unit_if dif ();

    div_issue_unit dut (
        .clk   (clk),
        .reset (reset),
        .io    (dif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

`ifdef DIV_RESULT_CACHE_EN
    logic        c_valid;
    logic [63:0] c_a, c_b;
    logic        c_s, c_w;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RV64M semantics computed directly from the architectural rules.
    function automatic void ref_model(input logic [1:0] code, input logic word,
                                      input logic [63:0] s1, input logic [63:0] s2,
                                      output logic [63:0] res, output logic fast,
                                      output logic [63:0] ea, output logic [63:0] eb,
                                      output logic es);
        logic        sgn, rem;
        logic [31:0] x, y, q32, r32;
        logic [63:0] q, r;
        sgn = (code == 2'd0) || (code == 2'd2);
        rem = (code >= 2'd2);
        es  = sgn;
        x   = s1[31:0];
        y   = s2[31:0];
        if (word) begin
            ea   = sgn ? {{32{x[31]}}, x} : {32'd0, x};
            eb   = sgn ? {{32{y[31]}}, y} : {32'd0, y};
            fast = (y == 32'd0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
            if (y == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = x; end
            else if (fast)  begin q32 = x; r32 = 32'd0; end
            else if (sgn)   begin q32 = $signed(x) / $signed(y); r32 = $signed(x) % $signed(y); end
            else            begin q32 = x / y; r32 = x % y; end
            res = rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end else begin
            ea   = s1;
            eb   = s2;
            fast = (s2 == 64'd0) || (sgn && s1 == 64'h8000_0000_0000_0000 && s2 == 64'hFFFF_FFFF_FFFF_FFFF);
            if (s2 == 64'd0) begin q = 64'hFFFF_FFFF_FFFF_FFFF; r = s1; end
            else if (fast)   begin q = s1; r = 64'd0; end
            else if (sgn)    begin q = $signed(s1) / $signed(s2); r = $signed(s1) % $signed(s2); end
            else             begin q = s1 / s2; r = s1 % s2; end
            res = rem ? r : q;
        end
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h0000_0000_8000_0000;
            4: v = 64'hFFFF_FFFF_8000_0000;
            5: v = 64'($urandom_range(1, 50));
            6: v = {$urandom, $urandom};
            default: v = -64'($urandom_range(1, 50));
        endcase
        return v;
    endfunction

    task automatic drive_op(input logic [1:0] code, input logic word,
                            input logic [63:0] s1, input logic [63:0] s2);
        dif.op_code  = code;
        dif.op_word  = word;
        dif.src1     = s1;
        dif.src2     = s2;
        dif.op_valid = 1'b1;
    endtask

    task automatic run_op(input logic [1:0] code, input logic word, input logic [63:0] s1,
                          input logic [63:0] s2, input int lat, input int hold);
        logic [63:0] exp_res, ea, eb, dq, dr;
        logic        fast, es, launch, hit;
        ref_model(code, word, s1, s2, exp_res, fast, ea, eb, es);
        hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        hit = !fast && c_valid && c_a == ea && c_b == eb && c_s == es && c_w == word;
`endif
        launch = !fast && !hit;
        @(negedge clk);
        check_eq("op_ready_idle", 64'(dif.op_ready), 64'd1);
        drive_op(code, word, s1, s2);
        @(negedge clk);
        dif.op_valid = 1'b0;
        check_eq("launch_t1", 64'(dif.div_in_valid), 64'(launch));
        check_eq("res_valid_t1", 64'(dif.res_valid), 64'(!launch));
        if (launch) begin
            check_eq("div_in_a", dif.div_in_a, ea);
            check_eq("div_in_b", dif.div_in_b, eb);
            check_eq("div_signed", 64'(dif.div_signed), 64'(es));
            if (es) begin
                dq = $signed(ea) / $signed(eb);
                dr = $signed(ea) % $signed(eb);
            end else begin
                dq = ea / eb;
                dr = ea % eb;
            end
            @(negedge clk);
            check_eq("start_pulse_len", 64'(dif.div_in_valid), 64'd0);
            for (int i = 0; i < lat; i++) begin
                check_eq("busy_no_result", 64'(dif.res_valid), 64'd0);
                @(negedge clk);
            end
            dif.div_result_valid = 1'b1;
            dif.div_quotient     = dq;
            dif.div_remainder    = dr;
            @(negedge clk);
            dif.div_result_valid = 1'b0;
            dif.div_quotient     = {$urandom, $urandom};
            dif.div_remainder    = {$urandom, $urandom};
            check_eq("res_valid_r1", 64'(dif.res_valid), 64'd1);
`ifdef DIV_RESULT_CACHE_EN
            c_valid = 1'b1; c_a = ea; c_b = eb; c_s = es; c_w = word;
`endif
        end
        check_eq("res_data", dif.res_data, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("res_valid_hold", 64'(dif.res_valid), 64'd1);
            check_eq("res_data_hold", dif.res_data, exp_res);
        end
        dif.res_ready = 1'b1;
        @(negedge clk);
        dif.res_ready = 1'b0;
        check_eq("res_valid_drop", 64'(dif.res_valid), 64'd0);
        check_eq("op_ready_back", 64'(dif.op_ready), 64'd1);
    endtask

    // where: 0 = flush in LAUNCH, 1 = in BUSY, 2 = in DONE; a late divider
    // pulse afterwards must be ignored.
    task automatic flush_test(input int where);
        @(negedge clk);
        drive_op(2'd0, 1'b0, 64'd1000 + 64'(where), 64'd3);
        @(negedge clk);
        dif.op_valid = 1'b0;
        if (where >= 1) @(negedge clk);
        if (where == 2) begin
            dif.div_result_valid = 1'b1;
            dif.div_quotient     = (64'd1000 + 64'(where)) / 64'd3;
            dif.div_remainder    = (64'd1000 + 64'(where)) % 64'd3;
            @(negedge clk);
            dif.div_result_valid = 1'b0;
            check_eq("flush_pre_done", 64'(dif.res_valid), 64'd1);
`ifdef DIV_RESULT_CACHE_EN
            c_valid = 1'b1; c_a = 64'd1002; c_b = 64'd3; c_s = 1'b1; c_w = 1'b0;
`endif
        end
        dif.flush = 1'b1;
        #1;
        check_eq("div_flush", 64'(dif.div_flush), 64'(where < 2));
        @(negedge clk);
        dif.flush = 1'b0;
        check_eq("flush_res_valid", 64'(dif.res_valid), 64'd0);
        check_eq("flush_in_valid", 64'(dif.div_in_valid), 64'd0);
        check_eq("flush_op_ready", 64'(dif.op_ready), 64'd1);
        check_eq("div_flush_idle", 64'(dif.div_flush), 64'd0);
        dif.div_result_valid = 1'b1;
        @(negedge clk);
        dif.div_result_valid = 1'b0;
        check_eq("late_result_ignored", 64'(dif.res_valid), 64'd0);
        check_eq("late_op_ready", 64'(dif.op_ready), 64'd1);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        dif.flush            = 1'b0;
        dif.op_valid         = 1'b0;
        dif.op_code          = 2'd0;
        dif.op_word          = 1'b0;
        dif.src1             = 64'd0;
        dif.src2             = 64'd0;
        dif.div_result_valid = 1'b0;
        dif.div_quotient     = 64'd0;
        dif.div_remainder    = 64'd0;
        dif.res_ready        = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        c_valid = 1'b0; c_a = 64'd0; c_b = 64'd0; c_s = 1'b0; c_w = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_op_ready", 64'(dif.op_ready), 64'd1);
        check_eq("rst_res_valid", 64'(dif.res_valid), 64'd0);
        check_eq("rst_res_data", dif.res_data, 64'd0);
        check_eq("rst_in_valid", 64'(dif.div_in_valid), 64'd0);
        check_eq("rst_in_a", dif.div_in_a, 64'd0);
        check_eq("rst_in_b", dif.div_in_b, 64'd0);
        check_eq("rst_signed", 64'(dif.div_signed), 64'd0);
        check_eq("rst_div_flush", 64'(dif.div_flush), 64'd0);

        run_op(2'd0, 1'b0, 64'd100, 64'd7, 2, 1);
        run_op(2'd3, 1'b0, 64'h55, 64'd0, 0, 0);
        run_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        run_op(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_op(2'd0, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 1, 0);
        run_op(2'd1, 1'b1, 64'h1234, 64'hABCD_0000_0000_0000, 0, 0);
        run_op(2'd0, 1'b0, 64'd100, 64'd7, 3, 0);
        run_op(2'd2, 1'b0, 64'd100, 64'd7, 1, 2);

        @(negedge clk);
        dif.div_result_valid = 1'b1;
        @(negedge clk);
        dif.div_result_valid = 1'b0;
        check_eq("stray_res_valid", 64'(dif.res_valid), 64'd0);
        check_eq("stray_op_ready", 64'(dif.op_ready), 64'd1);

        @(negedge clk);
        drive_op(2'd0, 1'b0, 64'd9, 64'd4);
        dif.flush = 1'b1;
        @(negedge clk);
        dif.op_valid = 1'b0;
        dif.flush    = 1'b0;
        check_eq("flush_accept_in_valid", 64'(dif.div_in_valid), 64'd0);
        check_eq("flush_accept_res_valid", 64'(dif.res_valid), 64'd0);
        check_eq("flush_accept_op_ready", 64'(dif.op_ready), 64'd1);

        for (int w = 0; w < 3; w++) flush_test(w);

        @(negedge clk);
        drive_op(2'd1, 1'b0, 64'd2000, 64'd9);
        @(negedge clk);
        dif.op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        c_valid = 1'b0;
`endif
        check_eq("midrst_op_ready", 64'(dif.op_ready), 64'd1);
        check_eq("midrst_res_valid", 64'(dif.res_valid), 64'd0);
        check_eq("midrst_res_data", dif.res_data, 64'd0);
        check_eq("midrst_in_a", dif.div_in_a, 64'd0);

        for (int n = 0; n < 80; n++) begin
            logic [63:0] s1, s2;
            s1 = pick_operand();
            s2 = pick_operand();
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), s1, s2,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0)
                run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), s1, s2, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
